// File: rtl/brightness_pkg.sv
// Gain constants shared by brightness_ctrl and the per-pixel brightness datapath.
// The datapath computes out = in * gain >> 3, so GAIN_DEFAULT means unity.
package brightness_pkg;

    localparam int GAIN_W = 4;

    typedef logic [GAIN_W-1:0] gain_t;

    localparam gain_t GAIN_MAX     = 4'd15;
    localparam gain_t GAIN_MIN     = 4'd0;
    localparam gain_t GAIN_DEFAULT = 4'd8;

    // One saturating step; opposing requests cancel.
    function automatic gain_t gain_step(gain_t lvl, logic up, logic dn);
        gain_step = lvl;
        if (up && !dn && lvl != GAIN_MAX)
            gain_step = lvl + gain_t'(1);
        else if (dn && !up && lvl != GAIN_MIN)
            gain_step = lvl - gain_t'(1);
    endfunction

endpackage

// File: rtl/brightness_ctrl_if.sv
// Frame sync in, gain levels out, between brightness_ctrl and the datapath.
// master = brightness_ctrl side, slave = datapath / video timing side.
interface brightness_ctrl_if
    import brightness_pkg::*;
();

    logic  vsync;
    gain_t gain;
    gain_t gain_pending;
    logic  gain_update;

    modport master (
        input  vsync,
        output gain,
        output gain_pending,
        output gain_update
    );

    modport slave (
        output vsync,
        input  gain,
        input  gain_pending,
        input  gain_update
    );

endinterface

// File: rtl/brightness_ctrl_key_debounce.sv
// Key synchroniser + debouncer + press pulse for one active-low button.
// Auto-repeat while held is built only with BRIGHTNESS_CTRL_AUTOREPEAT_EN.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
`ifdef BRIGHTNESS_CTRL_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          fall;

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (s2_q != db_q) begin
            if (cnt_q == CNT_LAST)
                db_d = ~db_q;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    assign fall = db_q & ~db_d;

`ifdef BRIGHTNESS_CTRL_AUTOREPEAT_EN
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW = $clog2(HMAX + 1);
    localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          rep_q, rep_d;
    logic          fire;

    // hold counts cycles since the last event; rep marks the periodic phase.
    always_comb begin
        hold_d = '0;
        rep_d  = 1'b0;
        fire   = 1'b0;
        if (!db_q && !db_d) begin
            if (hold_q == (rep_q ? PER_LAST : DLY_LAST)) begin
                fire  = 1'b1;
                rep_d = 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
                rep_d  = rep_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            rep_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end

    assign press_d = fall | fire;
`else
    assign press_d = fall;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            db_q    <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            s1_q    <= key_n;
            s2_q    <= s1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/brightness_ctrl.sv
// Button-driven 4-bit brightness gain, applied only at frame start.
// Optional auto-repeat: define BRIGHTNESS_CTRL_AUTOREPEAT_EN.
module brightness_ctrl
    import brightness_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_up_n,
    input  logic               key_dn_n,
    brightness_ctrl_if.master  bus
);

    logic  up_ev, dn_ev;
    logic  vs_q;
    logic  frame;
    gain_t pend_q, pend_d;
    gain_t gain_q, gain_d;
    logic  upd_q, upd_d;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BRIGHTNESS_CTRL_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_key_up (
        .clk   (clk),
        .reset (reset),
        .key_n (key_up_n),
        .press (up_ev)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BRIGHTNESS_CTRL_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_key_dn (
        .clk   (clk),
        .reset (reset),
        .key_n (key_dn_n),
        .press (dn_ev)
    );

`ifndef BRIGHTNESS_CTRL_AUTOREPEAT_EN
    logic unused_repeat;
    assign unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    // gain latches the pre-step pending value when both happen together.
    always_comb begin
        frame  = bus.vsync & ~vs_q;
        pend_d = gain_step(pend_q, up_ev, dn_ev);
        gain_d = gain_q;
        upd_d  = 1'b0;
        if (frame) begin
            gain_d = pend_q;
            upd_d  = (pend_q != gain_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vs_q   <= 1'b0;
            pend_q <= GAIN_DEFAULT;
            gain_q <= GAIN_DEFAULT;
            upd_q  <= 1'b0;
        end else begin
            vs_q   <= bus.vsync;
            pend_q <= pend_d;
            gain_q <= gain_d;
            upd_q  <= upd_d;
        end
    end

    assign bus.gain         = gain_q;
    assign bus.gain_pending = pend_q;
    assign bus.gain_update  = upd_q;

endmodule
